bcd_display_mux: RTL and testbench
==================================

BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 4: clock cycles each digit stays active; legal range 2..65535.
REQ-002 Parameter FLASH_CYCLES, default 16: length of the blank period after a hundreds carry; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 count10  input  4  ones BCD digit from the upstream counter.
REQ-006 count100  input  4  tens BCD digit from the upstream counter.
REQ-007 carry100  input  1  one-cycle pulse when the upstream counter wraps past 99/00.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 an  output  2  digit enables, active-low, registered; an[0]=ones digit, an[1]=tens digit.
REQ-010 flash  output  1  high while the wrap-blank period is active, registered.

Function
REQ-011 Refresh counter rc SHALL count 0..REFRESH_DIV-1 and wrap; select bit sel SHALL toggle on each wrap (sel=0 ones, sel=1 tens).
REQ-012 Shadow registers sh10/sh100 SHALL load count10/count100 only on the edge where sel goes 1->0; both digits of one frame always come from the same sample (no tearing).
REQ-013 an and seg SHALL be updated on the same edge as sel, from the new sel and new shadow values; an and seg never show different digits in the same cycle.
REQ-014 In SCAN state: sel=0 -> an=2'b10 with seg showing sh10; sel=1 -> an=2'b01 with seg showing sh100.
REQ-015 Decode, with a the LSB: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-016 Any digit value 10..15 SHALL decode to a dash, 0111111.
REQ-017 The FSM SHALL have two states, SCAN and FLASH. SCAN -> FLASH when carry100=1 is sampled; the flash counter loads FLASH_CYCLES-1.
REQ-018 In FLASH: an=2'b11, seg=1111111, flash=1. The flash counter decrements each cycle; FLASH -> SCAN on the edge after it reaches 0, so the blank period is exactly FLASH_CYCLES cycles.
REQ-019 carry100=1 sampled while in FLASH SHALL reload the counter to FLASH_CYCLES-1 (retrigger), extending the blank period.
REQ-020 rc, sel and the shadow loads SHALL keep running during FLASH; on return to SCAN the display resumes at the current sel with no phase reset.
REQ-021 carry100 held high for N cycles SHALL act as N consecutive retriggers; there is no edge detection.

Reset
REQ-022 While reset=0 at a rising edge: rc=0, sel=0, sh10=0, sh100=0, state=SCAN, flash counter=0, an=2'b11, seg=1111111, flash=0.
REQ-023 On the first edge with reset=1: an=2'b10 and seg shows sh10=0 (1000000); the first shadow load occurs at the end of that frame.
REQ-024 Reset asserted mid-FLASH or mid-frame SHALL abort to the REQ-022 values on that edge; any pending carry is discarded.

Configuration
REQ-025 Macro BCD_DISP_LZB_EN: when defined, in SCAN with sel=1 and sh100=0, seg=1111111 and an=2'b11 (tens digit blanked). When undefined, the tens digit always shows per REQ-015/016.
REQ-026 The macro SHALL affect nothing except the tens-digit blank condition: timing, FSM, and the ones digit are identical with and without it.

Verification (REFRESH_DIV=4, FLASH_CYCLES=8)
REQ-027 Reset low 2 cycles, then high, inputs 3/7 -> cycle 1: an=10, seg=1000000; cycles 5-8: an=01, seg=1000000 (LZB off) or an=11 (LZB on); cycle 9: an=10, seg=0110000 ("3").
REQ-028 Change count10 from 3 to 4 during the sel=1 slot -> the ones digit keeps showing 3 until the next 1->0 switch, then shows 0011001.
REQ-029 count10=12, count100=9 -> ones slot seg=0111111, tens slot seg=0010000.
REQ-030 One-cycle carry100 pulse in SCAN -> flash=1, an=11 for exactly 8 cycles, then scanning resumes with sel continuing its phase.
REQ-031 carry100 pulsed again 5 cycles into FLASH -> flash=1 persists 8 cycles after the second pulse (13 cycles total).
REQ-032 reset=0 during FLASH cycle 3 -> next edge: flash=0, an=11, seg=1111111; after release, behaviour matches REQ-027.

Source files
------------

// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed BCD display driver with a blank "flash" period after each hundreds carry.
// Optional macro BCD_DISP_LZB_EN blanks the tens digit when it is zero.
module bcd_display_mux #(
  parameter int unsigned REFRESH_DIV  = 4,
  parameter int unsigned FLASH_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count10,
  input  logic [3:0] count100,
  input  logic       carry100,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       flash
);

  localparam logic [15:0] RC_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] FC_LOAD = 16'(FLASH_CYCLES - 1);
  localparam logic [6:0]  SEG_OFF = 7'b1111111;

  typedef enum logic {ST_SCAN, ST_FLASH} state_t;

  state_t      state_q, state_d;
  logic [15:0] rc_q, rc_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        run_q, run_d;
  logic        sel_q, sel_d;
  logic [3:0]  sh10_q, sh10_d;
  logic [3:0]  sh100_q, sh100_d;
  logic [6:0]  seg_q, seg_d;
  logic [1:0]  an_q, an_d;
  logic        flash_q, flash_d;
  logic        wrap;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    run_d   = 1'b1;
    rc_d    = rc_q;
    sel_d   = sel_q;
    sh10_d  = sh10_q;
    sh100_d = sh100_q;
    state_d = state_q;
    fcnt_d  = fcnt_q;
    an_d    = 2'b11;
    seg_d   = SEG_OFF;
    flash_d = 1'b0;

    // The first edge after reset holds rc at 0 so the opening ones slot is a full REFRESH_DIV long.
    wrap = run_q && (rc_q == RC_LAST);
    if (run_q) rc_d = wrap ? 16'd0 : rc_q + 16'd1;
    if (wrap) begin
      sel_d = ~sel_q;
      if (sel_q) begin
        sh10_d  = count10;
        sh100_d = count100;
      end
    end

    case (state_q)
      ST_SCAN: begin
        if (carry100) begin
          state_d = ST_FLASH;
          fcnt_d  = FC_LOAD;
        end
      end
      ST_FLASH: begin
        if (carry100)            fcnt_d  = FC_LOAD;
        else if (fcnt_q == 16'd0) state_d = ST_SCAN;
        else                     fcnt_d  = fcnt_q - 16'd1;
      end
      default: state_d = ST_SCAN;
    endcase

    // Outputs are derived from next-state values so an/seg change on the same edge as sel.
    if (state_d == ST_FLASH) begin
      flash_d = 1'b1;
    end else if (!sel_d) begin
      an_d  = 2'b10;
      seg_d = decode(sh10_d);
    end else begin
`ifdef BCD_DISP_LZB_EN
      if (sh100_d != 4'd0) begin
        an_d  = 2'b01;
        seg_d = decode(sh100_d);
      end
`else
      an_d  = 2'b01;
      seg_d = decode(sh100_d);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_SCAN;
      rc_q    <= 16'd0;
      fcnt_q  <= 16'd0;
      run_q   <= 1'b0;
      sel_q   <= 1'b0;
      sh10_q  <= 4'd0;
      sh100_q <= 4'd0;
      an_q    <= 2'b11;
      seg_q   <= SEG_OFF;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      fcnt_q  <= fcnt_d;
      run_q   <= run_d;
      sel_q   <= sel_d;
      sh10_q  <= sh10_d;
      sh100_q <= sh100_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      flash_q <= flash_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign flash = flash_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux with REFRESH_DIV=4, FLASH_CYCLES=8.
// Honours BCD_DISP_LZB_EN for the zero-tens-digit expectations.
module tb_bcd_display_mux;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] count10 = 4'd0;
  logic [3:0] count100 = 4'd0;
  logic       carry100 = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       flash;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [1:0] ea;
  logic [6:0] es;
  logic       ef;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

`ifdef BCD_DISP_LZB_EN
  localparam logic [1:0] AN_T0  = 2'b11;
  localparam logic [6:0] SEG_T0 = 7'b1111111;
`else
  localparam logic [1:0] AN_T0  = 2'b01;
  localparam logic [6:0] SEG_T0 = 7'b1000000;
`endif

  bcd_display_mux #(.REFRESH_DIV(4), .FLASH_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .count10(count10), .count100(count100),
    .carry100(carry100), .seg(seg), .an(an), .flash(flash)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; count10 = 4'd3; count100 = 4'd7; carry100 = 1'b0;
    tick(); tick();
    n_tests++;
    if ({an, seg, flash} !== {2'b11, 7'b1111111, 1'b0}) begin
      n_fail++;
      $display("FAIL reset got an=%b seg=%b flash=%b want an=11 seg=1111111 flash=0", an, seg, flash);
    end
  endtask

  task automatic test_first_frame();
    reset = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k <= 4)      begin ea = 2'b10; es = 7'b1000000; end
      else if (k <= 8) begin ea = AN_T0; es = SEG_T0;     end
      else             begin ea = 2'b10; es = 7'b0110000; end
      n_tests++;
      if ({an, seg, flash} !== {ea, es, 1'b0}) begin
        n_fail++;
        $display("FAIL first_frame cyc=%0d got an=%b seg=%b flash=%b want an=%b seg=%b flash=0",
                 cyc, an, seg, flash, ea, es);
      end
    end
  endtask

  task automatic test_no_tearing();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin run_to(13); ea = 2'b01; es = 7'b1111000; end
        1: begin count10 = 4'd4; run_to(16); ea = 2'b01; es = 7'b1111000; end
        2: begin run_to(17); ea = 2'b10; es = 7'b0011001; end
        default: begin count100 = 4'd9; run_to(21); ea = 2'b01; es = 7'b1111000; end
      endcase
      n_tests++;
      if ({an, seg, flash} !== {ea, es, 1'b0}) begin
        n_fail++;
        $display("FAIL no_tearing cyc=%0d got an=%b seg=%b flash=%b want an=%b seg=%b flash=0",
                 cyc, an, seg, flash, ea, es);
      end
    end
  endtask

  task automatic test_dash();
    count10 = 4'd12; count100 = 4'd9;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin run_to(25); ea = 2'b10; es = 7'b0111111; end
      else        begin run_to(29); ea = 2'b01; es = 7'b0010000; end
      n_tests++;
      if ({an, seg, flash} !== {ea, es, 1'b0}) begin
        n_fail++;
        $display("FAIL dash cyc=%0d got an=%b seg=%b flash=%b want an=%b seg=%b flash=0",
                 cyc, an, seg, flash, ea, es);
      end
    end
  endtask

  task automatic test_flash();
    run_to(30);
    carry100 = 1'b1; tick(); carry100 = 1'b0;
    for (int k = 31; k <= 41; k++) begin
      run_to(k);
      if (k <= 38)      begin ea = 2'b11; es = 7'b1111111; ef = 1'b1; end
      else if (k <= 40) begin ea = 2'b01; es = 7'b0010000; ef = 1'b0; end
      else              begin ea = 2'b10; es = 7'b0111111; ef = 1'b0; end
      n_tests++;
      if ({an, seg, flash} !== {ea, es, ef}) begin
        n_fail++;
        $display("FAIL flash cyc=%0d got an=%b seg=%b flash=%b want an=%b seg=%b flash=%b",
                 cyc, an, seg, flash, ea, es, ef);
      end
    end
  endtask

  task automatic test_retrigger();
    carry100 = 1'b1; tick(); carry100 = 1'b0;
    for (int k = 42; k <= 55; k++) begin
      run_to(k);
      carry100 = 1'b0;
      if (k <= 54) begin ea = 2'b11; es = 7'b1111111; ef = 1'b1; end
      else         begin ea = 2'b01; es = 7'b0010000; ef = 1'b0; end
      n_tests++;
      if ({an, seg, flash} !== {ea, es, ef}) begin
        n_fail++;
        $display("FAIL retrigger cyc=%0d got an=%b seg=%b flash=%b want an=%b seg=%b flash=%b",
                 cyc, an, seg, flash, ea, es, ef);
      end
      if (k == 46) carry100 = 1'b1;
    end
    carry100 = 1'b0;
  endtask

  task automatic test_reset_in_flash();
    run_to(60);
    carry100 = 1'b1; tick(); carry100 = 1'b0;
    run_to(63);
    n_tests++;
    if (flash !== 1'b1) begin
      n_fail++;
      $display("FAIL flash_before_reset cyc=%0d got flash=%b want flash=1", cyc, flash);
    end
    reset = 1'b0; carry100 = 1'b1; count10 = 4'd3; count100 = 4'd7;
    tick();
    carry100 = 1'b0;
    n_tests++;
    if ({an, seg, flash} !== {2'b11, 7'b1111111, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_in_flash got an=%b seg=%b flash=%b want an=11 seg=1111111 flash=0", an, seg, flash);
    end
    tick();
    test_first_frame();
  endtask

  task automatic test_decode();
    for (int i = 0; i < 8; i++) begin
      count10 = 4'(2 * i); count100 = 4'(2 * i + 1);
      for (int j = 0; j < 2; j++) begin
        if (j == 0) begin run_to(8 * i + 17); ea = 2'b10; es = seg_tab[2 * i];     end
        else        begin run_to(8 * i + 21); ea = 2'b01; es = seg_tab[2 * i + 1]; end
        n_tests++;
        if ({an, seg, flash} !== {ea, es, 1'b0}) begin
          n_fail++;
          $display("FAIL decode cyc=%0d digit=%0d got an=%b seg=%b flash=%b want an=%b seg=%b flash=0",
                   cyc, 2 * i + j, an, seg, flash, ea, es);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_no_tearing();
    test_dash();
    test_flash();
    test_retrigger();
    test_reset_in_flash();
    test_decode();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
